// File: rtl/regfile_pkg.sv
// Shared constants for the 2-read/1-write register file: default geometry and
// the read-latency encodings.
package regfile_pkg;

    localparam int unsigned DEFAULT_DW   = 16;
    localparam int unsigned DEFAULT_NREG = 8;

    localparam int unsigned RL_COMB = 0;
    localparam int unsigned RL_REG  = 1;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: index mux over storage and busy bits, with an optional output
// register that bypasses this edge's write/claim so it shows post-edge state.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DW       = DEFAULT_DW,
    parameter int unsigned NREG     = DEFAULT_NREG,
    parameter int unsigned READ_LAT = RL_COMB,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREG-1:0][DW-1:0]  regs,
    input  logic [NREG-1:0]          busy,
    input  logic [AW-1:0]            readnum,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_idx,
    input  logic [DW-1:0]            wr_data,
    input  logic                     claim_en,
    input  logic [AW-1:0]            claim_idx,
    output logic [DW-1:0]            data_out,
    output logic                     busy_out
);

    logic [DW-1:0] data_q, data_d;
    logic          busy_q, busy_d;
    logic          wr_hit, claim_hit;

    always_comb begin
        wr_hit    = wr_en && (wr_idx == readnum);
        claim_hit = claim_en && (claim_idx == readnum);
        data_d    = wr_hit ? wr_data : regs[readnum];
        // Claim wins over a same-index write, matching the scoreboard update.
        busy_d    = claim_hit || (busy[readnum] && !wr_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    // Constant select; the unused path is pruned by synthesis.
    assign data_out = (READ_LAT == RL_REG) ? data_q : regs[readnum];
    assign busy_out = (READ_LAT == RL_REG) ? busy_q : busy[readnum];

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file: two read ports, one write port, synchronous clear
// and a per-register busy scoreboard for multicycle writers.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned DW       = DEFAULT_DW,
    parameter int unsigned NREG     = DEFAULT_NREG,
    parameter int unsigned READ_LAT = RL_COMB,
    parameter bit          ZERO_R0  = 1'b0,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   data_in,
    input  logic [AW-1:0]   writenum,
    input  logic            write,
    input  logic [AW-1:0]   readnum_a,
    input  logic [AW-1:0]   readnum_b,
    output logic [DW-1:0]   data_out_a,
    output logic [DW-1:0]   data_out_b,
    input  logic            claim,
    input  logic [AW-1:0]   claimnum,
    output logic            busy_a,
    output logic            busy_b,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0][DW-1:0] regs_q, regs_d;
    logic [NREG-1:0]         busy_q, busy_d;
    logic [NREG-1:0]         wr_onehot, claim_onehot;
    logic                    wr_ok, claim_ok;

    // With ZERO_R0, R0 is never written or claimed, so it stays at its reset value.
    assign wr_ok    = write && !(ZERO_R0 && (writenum == '0));
    assign claim_ok = claim && !(ZERO_R0 && (claimnum == '0));

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            wr_onehot[i]    = wr_ok && (writenum == AW'(i));
            claim_onehot[i] = claim_ok && (claimnum == AW'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = wr_onehot[i] ? data_in : regs_q[i];
        end
        busy_d = (busy_q & ~wr_onehot) | claim_onehot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    regfile_read_port #(
        .DW       (DW),
        .NREG     (NREG),
        .READ_LAT (READ_LAT)
    ) u_port_a (
        .clk       (clk),
        .reset     (reset),
        .regs      (regs_q),
        .busy      (busy_q),
        .readnum   (readnum_a),
        .wr_en     (wr_ok),
        .wr_idx    (writenum),
        .wr_data   (data_in),
        .claim_en  (claim_ok),
        .claim_idx (claimnum),
        .data_out  (data_out_a),
        .busy_out  (busy_a)
    );

    regfile_read_port #(
        .DW       (DW),
        .NREG     (NREG),
        .READ_LAT (READ_LAT)
    ) u_port_b (
        .clk       (clk),
        .reset     (reset),
        .regs      (regs_q),
        .busy      (busy_q),
        .readnum   (readnum_b),
        .wr_en     (wr_ok),
        .wr_idx    (writenum),
        .wr_data   (data_in),
        .claim_en  (claim_ok),
        .claim_idx (claimnum),
        .data_out  (data_out_b),
        .busy_out  (busy_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: three instances (comb read, registered read, registered
// read with hard-wired R0) share one stimulus and are checked against a model.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = '0;
    logic [2:0]  writenum = '0;
    logic        write = 1'b0;
    logic [2:0]  readnum_a = '0;
    logic [2:0]  readnum_b = '0;
    logic        claim = 1'b0;
    logic [2:0]  claimnum = '0;

    logic [15:0] dout_a [3];
    logic [15:0] dout_b [3];
    logic        bsy_a  [3];
    logic        bsy_b  [3];
    logic [7:0]  bvec   [3];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.DW(16), .NREG(8), .READ_LAT(0), .ZERO_R0(1'b0)) u_comb (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
        .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(dout_a[0]), .data_out_b(dout_b[0]),
        .claim(claim), .claimnum(claimnum),
        .busy_a(bsy_a[0]), .busy_b(bsy_b[0]), .busy_vec(bvec[0])
    );

    regfile_2r1w #(.DW(16), .NREG(8), .READ_LAT(1), .ZERO_R0(1'b0)) u_reg (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
        .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(dout_a[1]), .data_out_b(dout_b[1]),
        .claim(claim), .claimnum(claimnum),
        .busy_a(bsy_a[1]), .busy_b(bsy_b[1]), .busy_vec(bvec[1])
    );

    regfile_2r1w #(.DW(16), .NREG(8), .READ_LAT(1), .ZERO_R0(1'b1)) u_zero (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
        .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(dout_a[2]), .data_out_b(dout_b[2]),
        .claim(claim), .claimnum(claimnum),
        .busy_a(bsy_a[2]), .busy_b(bsy_b[2]), .busy_vec(bvec[2])
    );

    // Model: architectural state per instance; registered outputs hold the
    // post-edge view of the addressed register.
    bit          lat1  [3] = '{1'b0, 1'b1, 1'b1};
    bit          zr0   [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] m_mem [3][8];
    logic        m_busy[3][8];
    logic [15:0] m_qa  [3];
    logic [15:0] m_qb  [3];
    logic        m_qba [3];
    logic        m_qbb [3];
    bit          m_valid = 1'b0;

    task automatic chk(input string name, input int dut, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d at %0t: got 0x%0h expected 0x%0h",
                      name, dut, $time, act, exp);
    endtask

    // Applies the inputs about to be sampled at the coming edge.
    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                for (int r = 0; r < 8; r++) begin
                    m_mem[d][r]  = '0;
                    m_busy[d][r] = 1'b0;
                end
                m_qa[d] = '0; m_qb[d] = '0; m_qba[d] = 1'b0; m_qbb[d] = 1'b0;
            end else begin
                if (write && !(zr0[d] && writenum == 0)) begin
                    m_mem[d][writenum]  = data_in;
                    m_busy[d][writenum] = 1'b0;
                end
                if (claim && !(zr0[d] && claimnum == 0)) m_busy[d][claimnum] = 1'b1;
                m_qa[d]  = m_mem[d][readnum_a];
                m_qb[d]  = m_mem[d][readnum_b];
                m_qba[d] = m_busy[d][readnum_a];
                m_qbb[d] = m_busy[d][readnum_b];
            end
        end
        if (reset) m_valid = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare, mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int d = 0; d < 3; d++) begin
                logic [7:0] ev;
                for (int r = 0; r < 8; r++) ev[r] = m_busy[d][r];
                chk("busy_vec", d, 32'(bvec[d]), 32'(ev));
                if (lat1[d]) begin
                    chk("data_out_a", d, 32'(dout_a[d]), 32'(m_qa[d]));
                    chk("data_out_b", d, 32'(dout_b[d]), 32'(m_qb[d]));
                    chk("busy_a", d, 32'(bsy_a[d]), 32'(m_qba[d]));
                    chk("busy_b", d, 32'(bsy_b[d]), 32'(m_qbb[d]));
                end else begin
                    chk("data_out_a", d, 32'(dout_a[d]), 32'(m_mem[d][readnum_a]));
                    chk("data_out_b", d, 32'(dout_b[d]), 32'(m_mem[d][readnum_b]));
                    chk("busy_a", d, 32'(bsy_a[d]), 32'(m_busy[d][readnum_a]));
                    chk("busy_b", d, 32'(bsy_b[d]), 32'(m_busy[d][readnum_b]));
                end
            end
        end
    end

    initial begin
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state on every register, both ports.
        for (int r = 0; r < 8; r++) begin
            readnum_a = 3'(r);
            readnum_b = 3'(7 - r);
            cyc();
            chk("rst_a_lit", 0, 32'(dout_a[0]), 32'h0);
            chk("rst_b_lit", 1, 32'(dout_b[1]), 32'h0);
        end
        chk("rst_bvec_lit", 0, 32'(bvec[0]), 32'h00);

        // Combinational read-old, then new value after the edge on both ports.
        readnum_a = 3'd3; readnum_b = 3'd0;
        write = 1'b1; writenum = 3'd3; data_in = 16'hBEEF;
        #1;
        chk("comb_read_old", 0, 32'(dout_a[0]), 32'h0000);
        cyc();
        write = 1'b0; readnum_b = 3'd3;
        #1;
        chk("comb_read_new_a", 0, 32'(dout_a[0]), 32'hBEEF);
        chk("comb_read_new_b", 0, 32'(dout_b[0]), 32'hBEEF);

        // Registered read with write-first bypass.
        write = 1'b1; writenum = 3'd4; data_in = 16'h4444;
        cyc();
        writenum = 3'd5; data_in = 16'h1234; readnum_a = 3'd5; readnum_b = 3'd4;
        cyc();
        chk("reg_bypass_a", 1, 32'(dout_a[1]), 32'h1234);
        chk("reg_old_b", 1, 32'(dout_b[1]), 32'h4444);

        // Scoreboard on R2.
        write = 1'b0; claim = 1'b1; claimnum = 3'd2; readnum_a = 3'd2;
        cyc();
        chk("claim_bvec", 0, 32'(bvec[0]), 32'h04);
        chk("claim_busy_a", 0, 32'(bsy_a[0]), 32'h1);
        chk("claim_busy_a", 1, 32'(bsy_a[1]), 32'h1);
        write = 1'b1; writenum = 3'd2; data_in = 16'h00AA;
        cyc();
        chk("claim_wins_bvec", 0, 32'(bvec[0]), 32'h04);
        chk("claim_wins_data", 0, 32'(dout_a[0]), 32'h00AA);
        chk("claim_wins_busy", 1, 32'(bsy_a[1]), 32'h1);
        claim = 1'b0; data_in = 16'h00BB;
        cyc();
        chk("release_bvec", 0, 32'(bvec[0]), 32'h00);
        chk("release_data", 1, 32'(dout_a[1]), 32'h00BB);
        chk("release_busy", 1, 32'(bsy_a[1]), 32'h0);

        // Hard-wired R0 ignores writes and claims.
        writenum = 3'd0; data_in = 16'hFFFF; claim = 1'b1; claimnum = 3'd0;
        readnum_a = 3'd0;
        cyc();
        chk("r0_data", 2, 32'(dout_a[2]), 32'h0000);
        chk("r0_bvec", 2, 32'(bvec[2]), 32'h00);
        chk("r0_plain_data", 0, 32'(dout_a[0]), 32'hFFFF);
        chk("r0_plain_bvec", 0, 32'(bvec[0]), 32'h01);

        // Reset mid-operation beats a same-cycle write and claim.
        writenum = 3'd1; data_in = 16'h5555; claimnum = 3'd6; readnum_a = 3'd1;
        cyc();
        chk("pre_rst_bvec", 0, 32'(bvec[0]), 32'h41);
        chk("pre_rst_data", 0, 32'(dout_a[0]), 32'h5555);
        reset = 1'b1; data_in = 16'h7777; claimnum = 3'd3;
        cyc();
        reset = 1'b0; write = 1'b0; claim = 1'b0;
        #1;
        chk("rst_wins_data", 0, 32'(dout_a[0]), 32'h0000);
        chk("rst_wins_bvec", 0, 32'(bvec[0]), 32'h00);
        chk("rst_wins_regout", 1, 32'(dout_a[1]), 32'h0000);

        // Mixed traffic, including both ports on the same index.
        for (int i = 0; i < 16; i++) begin
            write     = (i % 3) != 2;
            writenum  = 3'(i * 3);
            data_in   = 16'(i * 16'h1357 + 1);
            claim     = (i % 4) == 0;
            claimnum  = 3'(i + 1);
            readnum_a = 3'(i);
            readnum_b = ((i % 4) == 1) ? 3'(i) : 3'(i * 5);
            cyc();
        end
        write = 1'b0; claim = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised successor to the 8x16 single-read register file in the datapath.
- Provides N registers of configurable width, with two independent read ports (A/B operand fetch) and one write port.
- Adds synchronous clear, an optional registered-read mode with write-first bypass, and a per-register busy scoreboard for multicycle writers such as memory loads.
- Sits between the instruction decoder and the ALU/shifter operand paths.

Parameters:
- DW, 16, data width in bits.
- NREG, 8, register count; must be a power of 2, at least 2.
- AW, log2(NREG) = 3, index width; derived localparam, not overridable.
- READ_LAT, 0, read latency: 0 = combinational read, 1 = registered read.
- ZERO_R0, 0, when 1, R0 reads as 0, writes to it are ignored, and it is never busy.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- data_in  in  DW  write data
- writenum  in  AW  write index
- write  in  1  write enable
- readnum_a  in  AW  read index, port A
- readnum_b  in  AW  read index, port B
- data_out_a  out  DW  read data, port A
- data_out_b  out  DW  read data, port B
- claim  in  1  mark register claimnum busy
- claimnum  in  AW  index to claim
- busy_a  out  1  busy bit of readnum_a; same timing as data_out_a
- busy_b  out  1  busy bit of readnum_b; same timing as data_out_b
- busy_vec  out  NREG  all busy bits, registered

Behaviour:
- Reset (synchronous, active-high):
  - On a clk edge with reset=1, all registers go to 0 and all busy bits to 0.
  - If READ_LAT=1, data_out_a/b and busy_a/b also go to 0.
  - reset overrides write and claim in the same cycle.
  - Reset asserted mid-claim discards the outstanding claim.
- Write:
  - On a clk edge with write=1 and reset=0, R[writenum] <= data_in.
  - All other registers hold.
  - If ZERO_R0=1 and writenum=0, the write is dropped.
- Read, READ_LAT=0:
  - data_out_x = R[readnum_x], purely combinational.
  - A same-cycle write is not visible until after the edge (read-old).
  - busy_x = busy[readnum_x], combinational.
- Read, READ_LAT=1:
  - At each edge, data_out_x <= R[readnum_x].
  - Write-first bypass: if write=1 and writenum==readnum_x (and the write is not dropped), data_out_x <= data_in.
  - busy_x is registered with the same bypass rule: it reflects busy state after this edge's claim/write.
- Both ports may address the same register and must return identical data.
- Scoreboard:
  - claim=1 sets busy[claimnum].
  - write=1 clears busy[writenum].
  - If claim and write target the same index in one cycle, claim wins and the bit stays set.
  - Claiming an already-busy register keeps it busy; no counting.
  - A write to a non-busy register is legal and leaves busy at 0.
  - ZERO_R0=1: claims on R0 are ignored.
- Index range: because NREG is a power of 2, every index is in range and no out-of-range handling is needed.
- No X on any output after the first reset edge.

Decomposition:
- Shared package (regfile_pkg):
  - default DW/NREG constants.
  - READ_LAT encodings RL_COMB=0 and RL_REG=1.
- One sub-module: regfile_read_port (index mux plus optional output register and bypass), instantiated twice.
- Storage, write decode and scoreboard stay in the top module.
- Reuse the existing one-hot decoder pattern for write decode.

Test Plan:
1. Reset, then read all 8 registers on both ports.
   -> All data_out = 0x0000, busy_vec = 8'h00.
2. READ_LAT=0: write R3=0xBEEF; the same cycle has readnum_a=3.
   -> data_out_a = 0x0000 before the edge, 0xBEEF after it. readnum_b=3 also gives 0xBEEF.
3. READ_LAT=1: write R5=0x1234 with readnum_a=5 in the same cycle.
   -> data_out_a = 0x1234 one cycle later (bypass). readnum_b=4 returns the old R4.
4. Scoreboard on R2:
   - claim R2 -> busy_vec = 8'h04, busy_a=1 for readnum_a=2.
   - Next cycle, claim R2 and write R2=0x00AA together -> busy stays 1, R2=0x00AA.
   - Next cycle, write R2=0x00BB -> busy_vec = 8'h00.
5. ZERO_R0=1: write R0=0xFFFF and claim R0.
   -> data_out_a = 0x0000, busy_vec[0]=0.
6. Reset mid-operation: R1=0x5555 and R6 claimed; assert reset together with write R1=0x7777.
   -> After the edge, R1=0x0000 and busy_vec=0 (reset wins).
